debounce_pulse: RTL and testbench
=================================

Name: debounce_pulse

Overview:
Multi-channel input conditioner for push-buttons and switches, the parametrised successor to the fixed 4-bit, 3-stage pulse shaper. Per channel it provides:
- a metastability synchroniser,
- a tick-gated stability counter producing a clean level,
- single-cycle rise/fall pulses,
- an optional auto-repeat "press" strobe for held buttons.
It sits between board pins and control FSMs in the cclk domain.

Parameters:
N, 4, number of independent channels
SYNC, 2, synchroniser flop stages (>=2)
STABLE, 3, consecutive differing samples (on tick) needed to accept a new level (>=1)
RPT_DLY, 0, ticks of continuous hold after rise before first repeat press; 0 disables auto-repeat
RPT_PER, 4, ticks between subsequent repeat presses (>=1, used only if RPT_DLY>0)

Ports:
cclk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-high reset
tick  input  1  sample enable, one cclk wide; tie 1 to sample every cycle
inp  input  N  raw asynchronous inputs
level  output  N  debounced level, registered
rise  output  N  one-cycle pulse when level goes 0->1
fall  output  N  one-cycle pulse when level goes 1->0
press  output  N  one-cycle pulse at rise plus each auto-repeat event

Behaviour:
- Reset: clr sampled on cclk edge. It clears sync chain, level, rise, fall, press, all counters to 0. clr wins over tick and any pending event.
- Synchroniser: SYNC-deep shift per channel, clocks every cycle regardless of tick. Its last stage is s[i].
- Stability counter cnt[i], width clog2(STABLE+1), updates only when tick=1:
  - s==level: cnt<=0.
  - s!=level and cnt+1<STABLE: cnt<=cnt+1.
  - s!=level and cnt+1==STABLE: level<=s, cnt<=0.
- Glitches shorter than STABLE ticks never reach level. STABLE=1: level follows s on every tick.
- tick=0: cnt, level, repeat counter frozen; rise/fall/press forced 0.
- Latency (tick=1 constant): level changes on the (SYNC+STABLE)th cclk edge after the first edge that captures the new inp value.
- Pulses: rise/fall/press are registered with level. rise[i]=1 exactly in the first cycle level[i] reads 1, and 0 the following cycle. fall is symmetric. Never multi-cycle.
- Repeat counter rcnt[i], width clog2(max(RPT_DLY,RPT_PER)+1):
  - Cleared in the cycle level updates (either direction) and whenever level=0.
  - While level=1 and tick=1, increments.
  - First repeat: press pulses when rcnt reaches RPT_DLY; rcnt then reloads to 0 and phase=PER.
  - In PER phase: press pulses when rcnt reaches RPT_PER; rcnt reloads to 0.
  - Phase flop per channel: DLY/PER, reset to DLY on rise, fall and clr.
- RPT_DLY=0: repeat logic absent, press==rise.
- Channels fully independent. Simultaneous events on different channels produce simultaneous pulses.
- Reset mid-debounce: partially counted transition discarded. After clr release, an input held 1 produces rise SYNC+STABLE edges later, like a fresh press.

Test Plan:
- Reset/idle: clr=1 for 3 cycles with inp=4'hF, then release, tick=1 -> level=0 and all pulses 0 during reset. level=4'hF and rise=4'hF (single cycle) on the 5th edge after release; press=rise.
- Clean press/release ch0: inp[0] 0->1 held 20 cycles, tick=1 -> rise[0] one cycle at edge 5. level[0]=1 until inp[0] drops. Then fall[0] one cycle 5 edges after drop. Other channels silent.
- Glitch rejection: inp[1] high for 2 cycles then low (STABLE=3) -> level, rise, fall stay 0. Repeat with 3-cycle pulse -> rise[1] then fall[1] 3 cycles later.
- Tick gating: tick every 4th cycle, inp[2] steps high -> level[2] rises on the 3rd tick after s[2]=1. No pulses in non-tick cycles. Hold tick=0 for 50 cycles -> no level change.
- Auto-repeat (RPT_DLY=4, RPT_PER=2, tick=1): hold inp[3] high 20 cycles -> press[3] at rise, then 4 ticks later, then every 2 ticks. Release -> press stops; a new press restarts the 4-tick delay.
- clr mid-operation: assert clr one cycle while ch0 cnt=2 and ch3 repeating -> all outputs 0 next cycle. No pulse emitted for the aborted transition; behaviour afterwards matches the reset scenario.

Source files
------------

// File: rtl/debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pulse
// Purpose  : N-channel input conditioner: synchroniser, tick-gated debounce,
//            rise/fall pulses and optional auto-repeat press strobe.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module debounce_pulse #(
    parameter int N       = 4,
    parameter int SYNC    = 2,
    parameter int STABLE  = 3,
    parameter int RPT_DLY = 0,
    parameter int RPT_PER = 4
) (
    input  logic         cclk,
    input  logic         clr,
    input  logic         tick,
    input  logic [N-1:0] inp,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] press
);

    localparam int             CW         = $clog2(STABLE + 1);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(STABLE - 1);

    logic [SYNC-1:0] r_sync [N];
    logic [CW-1:0]   r_cnt  [N];
    logic [N-1:0]    r_level;
    logic [N-1:0]    r_rise;
    logic [N-1:0]    r_fall;
    logic [N-1:0]    w_s;
    logic [N-1:0]    w_diff;
    logic [N-1:0]    w_acc;

    // w_acc marks the tick on which a channel accepts its new level
    always_comb begin
        w_s    = '0;
        w_diff = '0;
        w_acc  = '0;
        for (int i = 0; i < N; i++) begin
            w_s[i]    = r_sync[i][SYNC-1];
            w_diff[i] = w_s[i] ^ r_level[i];
            w_acc[i]  = tick && w_diff[i] && (r_cnt[i] == C_CNT_LAST);
        end
    end

    always_ff @(posedge cclk) begin
        if (clr) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < N; i++) begin
                r_sync[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < N; i++) begin
                r_sync[i] <= {r_sync[i][SYNC-2:0], inp[i]};
                if (tick) begin
                    if (!w_diff[i]) begin
                        r_cnt[i] <= '0;
                    end else if (w_acc[i]) begin
                        r_level[i] <= w_s[i];
                        r_rise[i]  <= w_s[i];
                        r_fall[i]  <= ~w_s[i];
                        r_cnt[i]   <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

    generate
        if (RPT_DLY > 0) begin : g_rpt
            localparam int             RMAX       = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
            localparam int             RW         = $clog2(RMAX + 1);
            localparam logic [RW-1:0]  C_DLY_LAST = RW'(RPT_DLY - 1);
            localparam logic [RW-1:0]  C_PER_LAST = RW'(RPT_PER - 1);
            localparam logic [0:0]     C_PH_DLY   = 1'b0;
            localparam logic [0:0]     C_PH_PER   = 1'b1;

            logic [RW-1:0] r_rcnt [N];
            logic [N-1:0]  r_phase;
            logic [N-1:0]  r_press;

            // Reaching the phase's last count fires a press and reloads,
            // so rcnt never holds the terminal value itself.
            always_ff @(posedge cclk) begin
                if (clr) begin
                    r_phase <= '0;
                    r_press <= '0;
                    for (int i = 0; i < N; i++) begin
                        r_rcnt[i] <= '0;
                    end
                end else begin
                    r_press <= '0;
                    for (int i = 0; i < N; i++) begin
                        if (w_acc[i] || !r_level[i]) begin
                            r_rcnt[i]  <= '0;
                            r_phase[i] <= C_PH_DLY;
                            r_press[i] <= w_acc[i] & w_s[i];
                        end else if (tick) begin
                            if (r_rcnt[i] == ((r_phase[i] == C_PH_PER) ? C_PER_LAST : C_DLY_LAST)) begin
                                r_press[i] <= 1'b1;
                                r_rcnt[i]  <= '0;
                                r_phase[i] <= C_PH_PER;
                            end else begin
                                r_rcnt[i] <= r_rcnt[i] + RW'(1);
                            end
                        end
                    end
                end
            end

            assign press = r_press;
        end else begin : g_norpt
            assign press = r_rise;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_pulse
// Purpose  : Directed self-checking bench for debounce_pulse (default and
//            auto-repeat configurations side by side).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_pulse;

    logic       cclk = 1'b0;
    logic       clr;
    logic       tick;
    logic [3:0] inp;
    logic [3:0] level,   rise,   fall,   press;
    logic [3:0] level_r, rise_r, fall_r, press_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 cclk = ~cclk;

    debounce_pulse u_dut (
        .cclk  (cclk),
        .clr   (clr),
        .tick  (tick),
        .inp   (inp),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .press (press)
    );

    debounce_pulse #(.RPT_DLY(4), .RPT_PER(2)) u_rpt (
        .cclk  (cclk),
        .clr   (clr),
        .tick  (tick),
        .inp   (inp),
        .level (level_r),
        .rise  (rise_r),
        .fall  (fall_r),
        .press (press_r)
    );

    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    task automatic do_reset();
        clr  = 1'b1;
        inp  = 4'h0;
        tick = 1'b1;
        step();
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] el, er;
        clr  = 1'b1;
        inp  = 4'hF;
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({level, rise, fall, press} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d level=%h rise=%h fall=%h press=%h (want 0)",
                         i, level, rise, fall, press);
            end
        end
        clr = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            el = (k >= 5) ? 4'hF : 4'h0;
            er = (k == 5) ? 4'hF : 4'h0;
            n_checks++;
            if (level !== el || rise !== er || fall !== 4'h0 || press !== er || press_r !== er) begin
                n_fail++;
                $display("FAIL reset_release k=%0d level=%h/%h rise=%h/%h fall=%h/0 press=%h/%h press_r=%h/%h",
                         k, level, el, rise, er, fall, press, er, press_r, er);
            end
        end
    endtask

    task automatic test_press();
        logic [3:0] el, er, ef;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            inp = (k <= 20) ? 4'h1 : 4'h0;
            step();
            el = (k >= 5 && k < 25) ? 4'h1 : 4'h0;
            er = (k == 5)  ? 4'h1 : 4'h0;
            ef = (k == 25) ? 4'h1 : 4'h0;
            n_checks++;
            if (level !== el || rise !== er || fall !== ef || press !== er) begin
                n_fail++;
                $display("FAIL press k=%0d level=%h/%h rise=%h/%h fall=%h/%h press=%h/%h",
                         k, level, el, rise, er, fall, ef, press, er);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] el, er, ef;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            inp = (k <= 2) ? 4'h2 : 4'h0;
            step();
            n_checks++;
            if ({level, rise, fall, press} !== 16'h0) begin
                n_fail++;
                $display("FAIL glitch2 k=%0d level=%h rise=%h fall=%h press=%h (want 0)",
                         k, level, rise, fall, press);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            inp = (k <= 3) ? 4'h2 : 4'h0;
            step();
            el = (k >= 5 && k < 8) ? 4'h2 : 4'h0;
            er = (k == 5) ? 4'h2 : 4'h0;
            ef = (k == 8) ? 4'h2 : 4'h0;
            n_checks++;
            if (level !== el || rise !== er || fall !== ef) begin
                n_fail++;
                $display("FAIL glitch3 k=%0d level=%h/%h rise=%h/%h fall=%h/%h",
                         k, level, el, rise, er, fall, ef);
            end
        end
    endtask

    task automatic test_tick();
        logic [3:0] el, er;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            tick = (k % 4 == 0);
            inp  = 4'h4;
            step();
            el = (k >= 12) ? 4'h4 : 4'h0;
            er = (k == 12) ? 4'h4 : 4'h0;
            n_checks++;
            if (level !== el || rise !== er || fall !== 4'h0 || press !== er) begin
                n_fail++;
                $display("FAIL tick_gate k=%0d level=%h/%h rise=%h/%h fall=%h/0 press=%h/%h",
                         k, level, el, rise, er, fall, press, er);
            end
        end
        tick = 1'b0;
        inp  = 4'h0;
        for (int k = 1; k <= 50; k++) begin
            step();
            n_checks++;
            if (level !== 4'h4 || {rise, fall, press, rise_r, fall_r, press_r} !== 24'h0) begin
                n_fail++;
                $display("FAIL tick_hold k=%0d level=%h/4 rise=%h fall=%h press=%h press_r=%h (want 0)",
                         k, level, rise, fall, press, press_r);
            end
        end
        tick = 1'b1;
    endtask

    task automatic test_repeat();
        logic [3:0] ep, er;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            inp = (k <= 20) ? 4'h8 : 4'h0;
            step();
            ep = (k == 5 || (k >= 9 && k <= 23 && (k % 2 == 1))) ? 4'h8 : 4'h0;
            er = (k == 5) ? 4'h8 : 4'h0;
            n_checks++;
            if (press_r !== ep || rise_r !== er || press !== er) begin
                n_fail++;
                $display("FAIL repeat k=%0d press_r=%h/%h rise_r=%h/%h press=%h/%h",
                         k, press_r, ep, rise_r, er, press, er);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            inp = 4'h8;
            step();
            ep = (k == 5 || k == 9 || k == 11) ? 4'h8 : 4'h0;
            n_checks++;
            if (press_r !== ep) begin
                n_fail++;
                $display("FAIL repeat_restart k=%0d press_r=%h/%h", k, press_r, ep);
            end
        end
    endtask

    task automatic test_clr_mid();
        logic [3:0] el, er, ep;
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            inp = (e >= 8) ? 4'h9 : 4'h8;
            step();
        end
        n_checks++;
        if (level !== 4'h8 || press_r !== 4'h8) begin
            n_fail++;
            $display("FAIL clr_setup level=%h/8 press_r=%h/8", level, press_r);
        end
        clr = 1'b1;
        step();
        n_checks++;
        if ({level, rise, fall, press, level_r, rise_r, fall_r, press_r} !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_mid level=%h rise=%h fall=%h press=%h level_r=%h rise_r=%h fall_r=%h press_r=%h (want 0)",
                     level, rise, fall, press, level_r, rise_r, fall_r, press_r);
        end
        clr = 1'b0;
        for (int e = 13; e <= 26; e++) begin
            step();
            el = (e >= 17) ? 4'h9 : 4'h0;
            er = (e == 17) ? 4'h9 : 4'h0;
            ep = (e == 17 || e == 21 || e == 23 || e == 25) ? 4'h9 : 4'h0;
            n_checks++;
            if (level !== el || rise !== er || fall !== 4'h0 || press !== er || press_r !== ep) begin
                n_fail++;
                $display("FAIL clr_after e=%0d level=%h/%h rise=%h/%h fall=%h/0 press=%h/%h press_r=%h/%h",
                         e, level, el, rise, er, fall, press, er, press_r, ep);
            end
        end
    endtask

    initial begin
        clr  = 1'b1;
        tick = 1'b1;
        inp  = 4'h0;
        test_reset();
        test_press();
        test_glitch();
        test_tick();
        test_repeat();
        test_clr_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
